// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: state encoding and
// width helpers used for parameter checking.
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_TERMS = 4;
    localparam int TERM_CNT_W        = $clog2(DEFAULT_NUM_TERMS) + 1;

    function automatic int term_cnt_width(input int num_terms);
        return $clog2(num_terms) + 1;
    endfunction

    // Smallest accumulator that cannot wrap when summing num_terms 8-bit products.
    function automatic int min_acc_width(input int num_terms);
        return 8 + $clog2(num_terms);
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums NUM_TERMS unsigned 8-bit products received over valid/ready and
// presents the registered total on a valid/ready output port.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter  int NUM_TERMS = 4,
    parameter  int ACC_WIDTH = 10,
    localparam int TCW       = term_cnt_width(NUM_TERMS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [TCW-1:0]       term_count
);

    localparam logic [TCW-1:0] LAST_TERM = TCW'(NUM_TERMS - 1);

    if (NUM_TERMS < 2 || NUM_TERMS > 256) begin : g_bad_num_terms
        $error("product_accumulator: NUM_TERMS must be in 2..256");
    end

    // Narrower accumulators are legal; the sum then wraps modulo 2^ACC_WIDTH.
    if (ACC_WIDTH < min_acc_width(NUM_TERMS)) begin : g_wrapping_acc
    end

    state_t               state;
    state_t               state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;
    logic                 accept;
    logic                 last;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready & ~clear;
    assign last     = (term_count == LAST_TERM);
    assign sum      = acc + ACC_WIDTH'(in_product);

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && last) state_nxt = HOLD;
                HOLD:    if (out_ready)      state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            term_count <= '0;
            out_sum    <= '0;
            out_valid  <= 1'b0;
        end else if (clear) begin
            acc        <= '0;
            term_count <= '0;
            out_valid  <= 1'b0;
        end else if (accept) begin
            if (last) begin
                out_sum    <= sum;
                acc        <= '0;
                term_count <= '0;
                out_valid  <= 1'b1;
            end else begin
                acc        <= sum;
                term_count <= term_count + TCW'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with hand-computed sums; a second
// instance with ACC_WIDTH=8 shares the stimulus to show modulo wrap.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_product = 8'd0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid;
    logic [9:0] out_sum;
    logic [2:0] term_count;

    logic       in_ready8, out_valid8;
    logic [7:0] out_sum8;
    logic [2:0] term_count8;

    int checks = 0;
    int errors = 0;

    product_accumulator #(.NUM_TERMS(4), .ACC_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .term_count(term_count)
    );

    product_accumulator #(.NUM_TERMS(4), .ACC_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .in_product(in_product),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_sum(out_sum8), .term_count(term_count8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product for a single cycle; caller knows in_ready is high.
    task automatic send(input logic [7:0] p);
        in_valid   = 1'b1;
        in_product = p;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    initial begin
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_term_count", 32'(term_count), 0);
        #11 reset = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 1);

        // 10+20+30+40 back to back, drained immediately
        send(8'd10); check("t1_tc1", 32'(term_count), 1);
        send(8'd20); check("t1_tc2", 32'(term_count), 2);
        send(8'd30); check("t1_tc3", 32'(term_count), 3);
        send(8'd40);
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_sum", 32'(out_sum), 100);
        check("t1_in_ready_low", 32'(in_ready), 0);
        check("t1_tc_wrap", 32'(term_count), 0);
        tick();
        check("t1_out_valid_drop", 32'(out_valid), 0);
        check("t1_in_ready_back", 32'(in_ready), 1);

        // 4 x 255: lossless at 10 bits, wraps at 8 bits
        send4(8'd255, 8'd255, 8'd255, 8'd255);
        check("t2_sum10", 32'(out_sum), 1020);
        check("t2_sum8", 32'(out_sum8), 252);
        check("t2_valid8", 32'(out_valid8), 1);
        tick();

        // gaps of 2 idle cycles between accepts
        send(8'd3);
        for (int k = 0; k < 3; k++) begin
            tick(); tick();
            check("t3_gap_hold", 32'(term_count), 32'(k + 1));
            if (k == 0) send(8'd5);
            else if (k == 1) send(8'd7);
            else send(8'd9);
            if (k < 2) check("t3_tc_step", 32'(term_count), 32'(k + 2));
        end
        check("t3_out_sum", 32'(out_sum), 24);
        check("t3_out_valid", 32'(out_valid), 1);
        tick();

        // backpressure: hold result for 6 cycles while upstream pushes
        out_ready = 1'b0;
        send4(8'd5, 8'd5, 8'd5, 8'd5);
        in_valid   = 1'b1;
        in_product = 8'd99;
        for (int k = 0; k < 6; k++) begin
            check("t4_hold_valid", 32'(out_valid), 1);
            check("t4_hold_sum", 32'(out_sum), 20);
            check("t4_hold_ready", 32'(in_ready), 0);
            check("t4_hold_tc", 32'(term_count), 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_released", 32'(out_valid), 0);
        send4(8'd1, 8'd1, 8'd1, 8'd1);
        check("t4_next_sum", 32'(out_sum), 4);
        tick();

        // clear mid-sum; the product offered with clear is dropped
        send(8'd50); send(8'd60);
        check("t5_tc_before_clear", 32'(term_count), 2);
        clear = 1'b1; in_valid = 1'b1; in_product = 8'd77;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("t5_tc_after_clear", 32'(term_count), 0);
        send4(8'd1, 8'd2, 8'd3, 8'd4);
        check("t5_sum", 32'(out_sum), 10);
        tick();

        // clear during HOLD drops the pending result
        out_ready = 1'b0;
        send4(8'd1, 8'd1, 8'd1, 8'd1);
        check("t5_hold_valid", 32'(out_valid), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clear_hold_valid", 32'(out_valid), 0);
        check("t5_clear_hold_ready", 32'(in_ready), 1);
        out_ready = 1'b1;

        // async reset between clock edges after 2 terms
        send(8'd7); send(8'd8);
        check("t6_tc_before_rst", 32'(term_count), 2);
        #3 reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 0);
        check("t6_async_sum", 32'(out_sum), 0);
        check("t6_async_tc", 32'(term_count), 0);
        #2 reset = 1'b0;
        tick();
        send4(8'd2, 8'd2, 8'd2, 8'd2);
        check("t6_sum", 32'(out_sum), 8);
        check("t6_valid", 32'(out_valid), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
